// File: rtl/hvsync_decoder.sv
// Receive-side video timing decoder: recovers active-area pixel coordinates from a
// blank/sync stream, measures line/frame geometry and reports LOCK once stable.
module hvsync_decoder #(
  parameter int TIMEOUT     = 1024,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       HBLK,
  input  logic       VBLK,
  input  logic       HSYN,
  input  logic       VSYN,
  output logic       DE,
  output logic [8:0] HPOS,
  output logic [8:0] VPOS,
  output logic [8:0] HACT,
  output logic [9:0] HTOT,
  output logic [8:0] VACT,
  output logic [9:0] VTOT,
  output logic       LOCK
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int MC_W = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_e;

  function automatic logic [8:0] sat9(input logic [9:0] x);
    return (x > 10'd511) ? 9'd511 : x[8:0];
  endfunction

  function automatic logic [9:0] sat10(input logic [10:0] x);
    return (x > 11'd1023) ? 10'd1023 : x[9:0];
  endfunction

  // Bit order of the sampled input vectors: {VSYN, HSYN, VBLK, HBLK}
  logic [3:0]      s_q, s_d, p_q, p_d;
  logic [1:0]      samp_q, samp_d;
  logic            de_q, de_d;
  logic [8:0]      hpos_q, hpos_d, hact_q, hact_d;
  logic [9:0]      hcnt_q, hcnt_d, htot_q, htot_d;
  logic [8:0]      line_q, line_d, vact_q, vact_d;
  logic [9:0]      hsc_q, hsc_d, vtot_q, vtot_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [MC_W-1:0] mcnt_q, mcnt_d;
  logic [37:0]     snap_q, snap_d;
  logic            lock_q, lock_d;
  lock_state_e     state_q, state_d;

  logic            edge_en, hblk_fall, hblk_rise, vblk_fall, vblk_rise;
  logic            hsyn_fall, vsyn_fall, timeout;
  logic [8:0]      line_base;
  logic [9:0]      hsc_inc;
  logic [37:0]     meas;

  // s/p start at 1, so the first sample after reset must not be compared against them
  assign edge_en   = (samp_q == 2'd2);
  assign hblk_fall = edge_en &  p_q[0] & ~s_q[0];
  assign hblk_rise = edge_en & ~p_q[0] &  s_q[0];
  assign vblk_fall = edge_en &  p_q[1] & ~s_q[1];
  assign vblk_rise = edge_en & ~p_q[1] &  s_q[1];
  assign hsyn_fall = edge_en &  p_q[2] & ~s_q[2];
  assign vsyn_fall = edge_en &  p_q[3] & ~s_q[3];

  always_comb begin
    s_d       = {VSYN, HSYN, VBLK, HBLK};
    p_d       = s_q;
    samp_d    = (samp_q == 2'd2) ? 2'd2 : samp_q + 2'd1;
    de_d      = ~(s_q[0] | s_q[1]);
    hpos_d    = hpos_q;
    hact_d    = hact_q;
    hcnt_d    = (hcnt_q == 10'd1023) ? hcnt_q : hcnt_q + 10'd1;
    htot_d    = htot_q;
    line_d    = line_q;
    line_base = line_q;
    vact_d    = vact_q;
    hsc_inc   = sat10({1'b0, hsc_q} + {10'd0, hsyn_fall});
    hsc_d     = hsc_inc;
    vtot_d    = vtot_q;
    wd_d      = wd_q;
    timeout   = 1'b0;
    mcnt_d    = mcnt_q;
    snap_d    = snap_q;
    lock_d    = lock_q;
    state_d   = state_q;
    meas      = '0;

    if (hblk_fall)      hpos_d = 9'd0;
    else if (!s_q[0])   hpos_d = hpos_q + 9'd1;
    if (hblk_rise)      hact_d = sat9({1'b0, hpos_q} + 10'd1);

    if (hsyn_fall) begin
      hcnt_d = 10'd0;
      htot_d = sat10({1'b0, hcnt_q} + 11'd1);
    end

    // Frame-start preset lands before the line increment so a coincident edge yields line 0
    if (vblk_fall)               line_base = 9'd511;
    if (hblk_fall && !s_q[1])    line_d = line_base + 9'd1;
    else                         line_d = line_base;
    if (vblk_rise)               vact_d = sat9({1'b0, line_q} + 10'd1);

    if (vsyn_fall) begin
      vtot_d = hsc_inc;
      hsc_d  = 10'd0;
    end

    if (hsyn_fall) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(TIMEOUT)) begin
      wd_d    = wd_q + WD_W'(1);
      timeout = (wd_q == WD_W'(TIMEOUT - 1));
    end

    meas = {htot_d, vtot_d, hact_d, vact_d};
    if (timeout) begin
      lock_d  = 1'b0;
      state_d = SEARCH;
    end else if (vsyn_fall) begin
      case (state_q)
        SEARCH: begin
          snap_d  = meas;
          mcnt_d  = MC_W'(1);
          state_d = TRACK;
        end
        TRACK: begin
          if (meas == snap_q) begin
            mcnt_d = mcnt_q + MC_W'(1);
            if (int'(mcnt_q) + 1 >= LOCK_FRAMES) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
            end
          end else begin
            snap_d = meas;
            mcnt_d = MC_W'(1);
          end
        end
        LOCKED: begin
          if (meas != snap_q) begin
            lock_d  = 1'b0;
            state_d = TRACK;
            snap_d  = meas;
            mcnt_d  = MC_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      s_q     <= 4'hF;
      p_q     <= 4'hF;
      samp_q  <= 2'd0;
      de_q    <= 1'b0;
      hpos_q  <= '0;
      hact_q  <= '0;
      hcnt_q  <= '0;
      htot_q  <= '0;
      line_q  <= '0;
      vact_q  <= '0;
      hsc_q   <= '0;
      vtot_q  <= '0;
      wd_q    <= '0;
      mcnt_q  <= '0;
      snap_q  <= '0;
      lock_q  <= 1'b0;
      state_q <= SEARCH;
    end else begin
      s_q     <= s_d;
      p_q     <= p_d;
      samp_q  <= samp_d;
      de_q    <= de_d;
      hpos_q  <= hpos_d;
      hact_q  <= hact_d;
      hcnt_q  <= hcnt_d;
      htot_q  <= htot_d;
      line_q  <= line_d;
      vact_q  <= vact_d;
      hsc_q   <= hsc_d;
      vtot_q  <= vtot_d;
      wd_q    <= wd_d;
      mcnt_q  <= mcnt_d;
      snap_q  <= snap_d;
      lock_q  <= lock_d;
      state_q <= state_d;
    end
  end

  assign DE   = de_q;
  assign HPOS = hpos_q;
  assign VPOS = line_q;
  assign HACT = hact_q;
  assign HTOT = htot_q;
  assign VACT = vact_q;
  assign VTOT = vtot_q;
  assign LOCK = lock_q;

endmodule

// File: tb/tb_hvsync_decoder.sv
// Directed bench for hvsync_decoder using a scaled-down raster (48-cycle lines,
// 32 active pixels, 20-line frames, 14 active lines) so the run stays short.
module tb_hvsync_decoder;

  logic       PCLK = 1'b0;
  logic       RESET, HBLK, VBLK, HSYN, VSYN;
  logic       DE, LOCK;
  logic [8:0] HPOS, VPOS, HACT, VACT;
  logic [9:0] HTOT, VTOT;

  int n_cmp = 0;
  int n_bad = 0;

  // Values captured at fixed raster points inside run_frame
  int st_lock, st_htot, st_vtot, st_hact, st_vact;
  int lp_de, lp_hpos, lp_vpos;
  int fp_de, fp_hpos, fp_vpos;

  hvsync_decoder #(.TIMEOUT(1024), .LOCK_FRAMES(2)) dut (
    .PCLK(PCLK), .RESET(RESET), .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
    .DE(DE), .HPOS(HPOS), .VPOS(VPOS), .HACT(HACT), .HTOT(HTOT),
    .VACT(VACT), .VTOT(VTOT), .LOCK(LOCK)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic hb, input logic vb, input logic hs, input logic vs);
    HBLK = hb; VBLK = vb; HSYN = hs; VSYN = vs;
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".DE"},   int'(DE),   0);
    check_eq({tag, ".HPOS"}, int'(HPOS), 0);
    check_eq({tag, ".VPOS"}, int'(VPOS), 0);
    check_eq({tag, ".HACT"}, int'(HACT), 0);
    check_eq({tag, ".HTOT"}, int'(HTOT), 0);
    check_eq({tag, ".VACT"}, int'(VACT), 0);
    check_eq({tag, ".VTOT"}, int'(VTOT), 0);
    check_eq({tag, ".LOCK"}, int'(LOCK), 0);
  endtask

  // One frame: HSYN low cycles 0..3, HBLK high cycles 0..H-A-1,
  // VSYN low lines 0..1, VBLK high lines 0..V-L-1. rst_line<0 means no reset pulse.
  task automatic run_frame(input int H, input int A, input int V, input int L, input int rst_line);
    for (int ln = 0; ln < V; ln++) begin
      for (int c = 0; c < H; c++) begin
        RESET = (ln == rst_line && c == 20);
        drive(c < H - A, ln < V - L, !(c < 4), !(ln < 2));
        if (RESET) begin
          RESET = 1'b0;
          check_all_zero("midreset");
        end
        if (ln == 0 && c == 0) begin
          lp_de = int'(DE); lp_hpos = int'(HPOS); lp_vpos = int'(VPOS);
        end
        if (ln == 0 && c == 1) begin
          st_lock = int'(LOCK); st_htot = int'(HTOT); st_vtot = int'(VTOT);
          st_hact = int'(HACT); st_vact = int'(VACT);
        end
        if (ln == V - L && c == H - A + 1) begin
          fp_de = int'(DE); fp_hpos = int'(HPOS); fp_vpos = int'(VPOS);
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    HBLK = 1'b1; VBLK = 1'b1; HSYN = 1'b1; VSYN = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 1);
    check_all_zero("reset");
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 1);

    // Standard timing: lock after the third frame start
    run_frame(48, 32, 20, 14, -1);
    check_eq("f1.lock", st_lock, 0);
    run_frame(48, 32, 20, 14, -1);
    check_eq("f2.lock", st_lock, 0);
    check_eq("f2.htot", st_htot, 48);
    check_eq("f2.vtot", st_vtot, 20);
    check_eq("f2.hact", st_hact, 32);
    check_eq("f2.vact", st_vact, 14);
    check_eq("f2.first.de",   fp_de,   1);
    check_eq("f2.first.hpos", fp_hpos, 0);
    check_eq("f2.first.vpos", fp_vpos, 0);
    run_frame(48, 32, 20, 14, -1);
    check_eq("f3.lock", st_lock, 1);
    check_eq("f3.vtot", st_vtot, 20);
    check_eq("f2.last.de",   lp_de,   1);
    check_eq("f2.last.hpos", lp_hpos, 31);
    check_eq("f2.last.vpos", lp_vpos, 13);

    // Frame height change 20 -> 19 while locked
    run_frame(48, 32, 19, 14, -1);
    check_eq("f4.lock", st_lock, 1);
    run_frame(48, 32, 19, 14, -1);
    check_eq("f5.lock", st_lock, 0);
    check_eq("f5.vtot", st_vtot, 19);
    run_frame(48, 32, 19, 14, -1);
    check_eq("f6.lock", st_lock, 1);
    check_eq("f6.vtot", st_vtot, 19);

    // HSYN stops for 1100 cycles; lock drops 1024 cycles after the last HSYN fall
    for (int k = 1; k <= 1100; k++) begin
      drive(1, 1, 1, 1);
      if (k == 970)  check_eq("stall970.lock", int'(LOCK), 1);
      if (k == 990)  check_eq("stall990.lock", int'(LOCK), 0);
    end
    check_eq("stall.lock", int'(LOCK), 0);
    check_eq("stall.hpos", int'(HPOS), 31);
    check_eq("stall.vpos", int'(VPOS), 13);
    check_eq("stall.htot", int'(HTOT), 48);

    // Resume: first HSYN fall closes an over-long line, HTOT saturates
    run_frame(48, 32, 20, 14, -1);
    check_eq("r1.lock", st_lock, 0);
    check_eq("r1.htot_sat", st_htot, 1023);
    run_frame(48, 32, 20, 14, -1);
    check_eq("r2.lock", st_lock, 0);
    check_eq("r2.htot", st_htot, 48);
    run_frame(48, 32, 20, 14, -1);
    check_eq("r3.lock", st_lock, 1);

    // Reset mid-line while locked; two frame starts must pass before relock
    run_frame(48, 32, 20, 14, 10);
    check_eq("r4.lock", st_lock, 1);
    run_frame(48, 32, 20, 14, -1);
    check_eq("r5.lock", st_lock, 0);
    run_frame(48, 32, 20, 14, -1);
    check_eq("r6.lock", st_lock, 0);
    run_frame(48, 32, 20, 14, -1);
    check_eq("r7.lock", st_lock, 1);
    check_eq("r7.vtot", st_vtot, 20);
    check_eq("r7.htot", st_htot, 48);
    check_eq("r7.hact", st_hact, 32);
    check_eq("r7.vact", st_vact, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hvsync_decoder.md
Name: hvsync_decoder

Overview:
- Receive-side counterpart of the video timing generator.
- Consumes a blank/sync stream (HBLK, VBLK, HSYN, VSYN, active-low syncs) and recovers the pixel position within the active area.
- Measures line and frame geometry and raises LOCK once the timing is stable.
- Used to re-derive coordinates for downstream overlay and scaler logic, and to check the generator in place.

Parameters:
- TIMEOUT, 1024: PCLK cycles without an HSYN falling edge before lock is dropped.
- LOCK_FRAMES, 2: consecutive frames with identical measurements required to assert LOCK.

Ports:
- PCLK  input  1  pixel clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- HBLK  input  1  horizontal blank; 1 = blanked.
- VBLK  input  1  vertical blank; 1 = blanked.
- HSYN  input  1  horizontal sync, active low.
- VSYN  input  1  vertical sync, active low.
- DE  output  1  active-pixel strobe, equal to the registered ~(HBLK|VBLK).
- HPOS  output  9  pixel index within the active line.
- VPOS  output  9  line index within the active frame.
- HACT  output  9  measured active pixels per line.
- HTOT  output  10  measured PCLK cycles per line.
- VACT  output  9  measured active lines per frame.
- VTOT  output  10  measured lines per frame.
- LOCK  output  1  timing is stable.

Behaviour:
- Input stage:
  - All four inputs are registered once (stage s) with a previous copy (stage p).
  - Edges are taken from s vs p.
  - Edge detection has no effect until two samples have been taken after reset.
- Reset values:
  - DE=0, HPOS=0, VPOS=0, HACT=0, HTOT=0, VACT=0, VTOT=0, LOCK=0.
  - Internal counters 0; match counter 0; s/p input copies set to 1.
- DE timing: DE = ~(s.HBLK|s.VBLK), registered. Latency from an input change to DE is 2 PCLK.
- HPOS:
  - Cleared to 0 in the same cycle DE first rises on a line (HBLK s-fall).
  - Increments by 1 each cycle while s.HBLK=0, wrapping at 511.
  - Holds its value during blank.
- HACT: on each HBLK s-rise, HACT <= HPOS+1 (width of the line just ended). HACT saturates at 511.
- HTOT:
  - Free-running 10-bit cycle counter, cleared on each HSYN s-fall.
  - On that fall, HTOT <= counter+1.
  - The counter saturates at 1023; if saturated, HTOT=1023.
- VPOS and VACT:
  - On VBLK s-fall, internal line counter <= 511 (all ones).
  - On each HBLK s-fall with s.VBLK=0, line counter <= line counter+1, wrapping 511 to 0. VPOS = line counter, so the first active line reads 0.
  - On VBLK s-rise, VACT <= line counter+1.
- VTOT:
  - Counts HSYN s-falls and is cleared on each VSYN s-fall.
  - On that fall, VTOT <= count. If the same cycle holds an HSYN s-fall, that edge is counted.
  - Saturates at 1023.
- Lock state machine (states SEARCH, TRACK, LOCKED), evaluated at each VSYN s-fall after VTOT/HTOT update:
  - SEARCH: snapshot {HTOT,VTOT,HACT,VACT}, match counter=1, go to TRACK.
  - TRACK: if the new values equal the snapshot, match counter+1. When the count reaches LOCK_FRAMES, go to LOCKED and set LOCK=1 the next cycle. On any mismatch, re-snapshot and set match counter=1.
  - LOCKED: on any mismatch, LOCK=0, go to TRACK with a new snapshot and match counter=1.
- Timeout:
  - A watchdog counts cycles since the last HSYN s-fall.
  - At TIMEOUT, from any state: LOCK=0, go to SEARCH, VPOS/HPOS hold, measurements keep their last values.
  - The watchdog saturates and does not retrigger until an HSYN edge.
- Simultaneous events:
  - VBLK s-fall and HBLK s-fall in the same cycle: the preset to 511 is applied first, then the increment, so VPOS=0.
  - HBLK s-rise and s-fall cannot coexist.
- Reset mid-frame: all state returns to reset values on the next edge.
  - The first full frame after reset is never counted toward lock, because VTOT needs two VSYN edges.

Test Plan:
1. Standard timing: 384-cycle lines with HBLK low 256 cycles, 263-line frames with VBLK low 224 lines, 3 frames -> HTOT=384, HACT=256, VTOT=263, VACT=224. LOCK=1 after the 3rd VSYN fall; remains 1.
2. Position check in frame 2: first active pixel -> DE=1 two PCLK after HBLK falls, HPOS=0, VPOS=0. Last active pixel -> HPOS=255, VPOS=223.
3. Geometry change while LOCKED (VTOT 263 to 262) -> LOCK=0 at the next VSYN fall, VTOT=262. LOCK=1 again one frame later.
4. Stop toggling HSYN for 1100 cycles while LOCKED -> LOCK=0 at cycle 1024. Resume standard timing -> LOCK=1 after 3 VSYN falls.
5. Assert RESET for 1 cycle mid-line while LOCKED -> all outputs 0 next cycle. LOCK stays 0 through the first 2 VSYN falls after release.
6. Line longer than 1023 cycles -> HTOT saturates at 1023, no wrap.
